signed_bcd_formatter: RTL



---
 rtl/number_format_pkg.sv | 31 +++
 rtl/bcd_digit_adjust.sv | 12 +
 rtl/signed_bcd_formatter.sv | 102 ++++++++++
 3 files changed

// File: rtl/number_format_pkg.sv
// Shared types and constants for the binary-to-decimal display formatter.
// Holds the FSM encoding, the double-dabble adjust constants and the digit-count helper.
package number_format_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Minimum decimal digits needed to show 2^width - 1.
    function automatic int digits_needed(input int width);
        longint unsigned max_val;
        longint unsigned pow10;
        int              d;
        max_val = (64'd1 << width) - 64'd1;
        pow10   = 64'd10;
        d       = 1;
        for (int i = 0; i < 19; i++) begin
            if (pow10 <= max_val) begin
                pow10 = pow10 * 64'd10;
                d     = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit of the shift-and-add-3 step: adds 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
    import number_format_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= BCD_ADJ_THRESH) ? (digit + BCD_ADJ_ADD) : digit;

endmodule

// File: rtl/signed_bcd_formatter.sv
// Sequential double-dabble converter: WIDTH-bit value (signed or unsigned) to sign
// plus DIGITS BCD digits, one shift per clock, with a start/busy/done handshake.
module signed_bcd_formatter
    import number_format_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic [WIDTH-1:0]      din,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd,
    output state_t                dbg_state
);

    // Handshake: start/is_signed/din are sampled only on an edge where the FSM is
    // IDLE; busy covers the load edge up to the result update, done is a one-cycle
    // pulse coincident with the new bcd/neg values. Requests outside IDLE are dropped.

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    if (DIGITS < digits_needed(WIDTH)) begin : g_digits_check
        $error("signed_bcd_formatter: DIGITS too small for WIDTH");
    end

    state_t                state;
    logic                  neg_r;
    logic [WIDTH-1:0]      mag;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   scratch_adj;
    logic [CNT_W-1:0]      count;

    logic                  neg_in;
    logic [WIDTH-1:0]      mag_in;

    // Two's-complement negate kept at WIDTH bits so the most negative value maps to 2^(WIDTH-1).
    assign neg_in = is_signed & din[WIDTH-1];
    assign mag_in = neg_in ? (~din + WIDTH'(1)) : din;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (scratch[4*g +: 4]),
            .adjusted (scratch_adj[4*g +: 4])
        );
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            neg     <= 1'b0;
            bcd     <= '0;
            neg_r   <= 1'b0;
            mag     <= '0;
            scratch <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neg_r   <= neg_in;
                        mag     <= mag_in;
                        scratch <= '0;
                        count   <= CNT_LOAD;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= {scratch_adj[4*DIGITS-2:0], mag[WIDTH-1]};
                    mag     <= {mag[WIDTH-2:0], 1'b0};
                    count   <= count - CNT_LAST;
                    if (count == CNT_LAST) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bcd   <= scratch;
                    neg   <= neg_r;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
